svc_axi_stripe_rd: RTL and testbench

Read-side companion to the striped write path. Accepts AXI read bursts from one manager and splits each burst across NUM_S subordinates by the low-order beat-address bits. It then reassembles the R beats from the subordinates, in original address order, into a single R stream back to the manager. It sits between a manager (or arbiter output) and NUM_S parallel memory controllers.

---
 rtl/svc_axi_stripe_rd_pkg.sv | 33 +++
 rtl/svc_axi_stripe_ax.sv | 46 ++++
 rtl/svc_skidbuf.sv | 44 ++++
 rtl/svc_sync_fifo.sv | 39 +++
 rtl/svc_axi_stripe_rd.sv | 170 +++++++++++++++++
 tb/tb_svc_axi_stripe_rd.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/svc_axi_stripe_rd_pkg.sv
// Shared definitions for the striped AXI paths: stripe index/offset widths,
// per-subordinate beat split, and the read reassembly state encoding.
package svc_axi_stripe_rd_pkg;

    typedef struct packed {
        logic       valid;
        logic [7:0] len;
    } stripe_split_t;

    typedef enum logic {
        R_HEAD,
        R_BURST
    } r_state_t;

    function automatic int unsigned stripe_idx_w(input int unsigned num_s);
        return $clog2(num_s);
    endfunction

    function automatic int unsigned stripe_off_w(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // k is the subordinate's beat offset from the burst start stripe.
    function automatic stripe_split_t stripe_split(input logic [7:0] k,
                                                   input logic [7:0] len,
                                                   input int unsigned s);
        stripe_split_t r;
        r.valid = (k <= len);
        r.len   = r.valid ? ((len - k) >> s) : '0;
        return r;
    endfunction

endpackage

// File: rtl/svc_axi_stripe_ax.sv
// Splits one AXI address/len into per-subordinate stripe address, len and valid.
module svc_axi_stripe_ax
    import svc_axi_stripe_rd_pkg::*;
#(
    parameter int unsigned NUM_S            = 2,
    parameter int unsigned AXI_ADDR_WIDTH   = 8,
    parameter int unsigned AXI_DATA_WIDTH   = 16,
    parameter int unsigned S_AXI_ADDR_WIDTH = AXI_ADDR_WIDTH - $clog2(NUM_S)
) (
    input  logic [AXI_ADDR_WIDTH-1:0]         addr,
    input  logic [7:0]                        len,
    output logic [$clog2(NUM_S)-1:0]          start_idx,
    output logic [NUM_S-1:0]                  sub_valid,
    output logic [NUM_S*S_AXI_ADDR_WIDTH-1:0] sub_addr,
    output logic [NUM_S*8-1:0]                sub_len
);

    localparam int unsigned S   = stripe_idx_w(NUM_S);
    localparam int unsigned O   = stripe_off_w(AXI_DATA_WIDTH);
    localparam int unsigned SAW = S_AXI_ADDR_WIDTH;
    localparam logic [SAW-1:0] LO_MASK = SAW'((1 << O) - 1);
    localparam logic [SAW-1:0] BEAT    = SAW'(1 << O);

    logic [SAW-1:0] base;
    logic [S-1:0]   k;
    stripe_split_t  split;

    always_comb begin
        start_idx = S'(addr >> O);
        // Drop the stripe-select bits, keep the in-beat byte offset.
        base      = (SAW'(addr >> (O + S)) << O) | (SAW'(addr) & LO_MASK);
        sub_valid = '0;
        sub_addr  = '0;
        sub_len   = '0;
        k         = '0;
        split     = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            k                      = S'(i) - start_idx;
            split                  = stripe_split(8'(k), len, S);
            sub_valid[i]           = split.valid;
            sub_len[i*8 +: 8]      = split.len;
            sub_addr[i*SAW +: SAW] = base + ((S'(i) < start_idx) ? BEAT : '0);
        end
    end

endmodule

// File: rtl/svc_skidbuf.sv
// Two-entry skid buffer: registered output, in_ready depends only on local state.
module svc_skidbuf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid  <= in_valid;
            end
        end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (out_ready || !out_valid) begin
            out_data <= skid_valid ? skid_data : in_data;
        end else if (in_valid && in_ready) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/svc_sync_fifo.sv
// Synchronous show-ahead FIFO with 2**ADDR_WIDTH entries.
module svc_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            if (rd_en && !empty) rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

endmodule

// File: rtl/svc_axi_stripe_rd.sv
// Striped AXI read: fans one AR burst out to NUM_S subordinates and merges
// their R beats back into address order for the manager.
module svc_axi_stripe_rd
    import svc_axi_stripe_rd_pkg::*;
#(
    parameter int unsigned NUM_S             = 2,
    parameter int unsigned AXI_ADDR_WIDTH    = 8,
    parameter int unsigned AXI_DATA_WIDTH    = 16,
    parameter int unsigned AXI_ID_WIDTH      = 4,
    parameter int unsigned S_AXI_ADDR_WIDTH  = AXI_ADDR_WIDTH - $clog2(NUM_S),
    parameter int unsigned OUTSTANDING_WIDTH = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]           s_axi_arid,
    input  logic [7:0]                        s_axi_arlen,
    input  logic [2:0]                        s_axi_arsize,
    input  logic [1:0]                        s_axi_arburst,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]           s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic [NUM_S-1:0]                  m_axi_arvalid,
    input  logic [NUM_S-1:0]                  m_axi_arready,
    output logic [NUM_S*S_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [NUM_S*AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [NUM_S*8-1:0]                m_axi_arlen,
    output logic [NUM_S*3-1:0]                m_axi_arsize,
    output logic [NUM_S*2-1:0]                m_axi_arburst,
    input  logic [NUM_S-1:0]                  m_axi_rvalid,
    output logic [NUM_S-1:0]                  m_axi_rready,
    input  logic [NUM_S*AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [NUM_S*AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [NUM_S*2-1:0]                m_axi_rresp,
    input  logic [NUM_S-1:0]                  m_axi_rlast
);

    localparam int unsigned S   = stripe_idx_w(NUM_S);
    localparam int unsigned AW  = AXI_ADDR_WIDTH;
    localparam int unsigned DW  = AXI_DATA_WIDTH;
    localparam int unsigned IW  = AXI_ID_WIDTH;
    localparam int unsigned ARW = AW + IW + 8 + 3 + 2;

    logic                          ar_valid, ar_ready, ar_accept;
    logic [ARW-1:0]                ar_data;
    logic [AW-1:0]                 ar_addr;
    logic [IW-1:0]                 ar_id;
    logic [7:0]                    ar_len;
    logic [2:0]                    ar_size;
    logic [1:0]                    ar_burst;
    logic [S-1:0]                  ar_start;
    logic [NUM_S-1:0]              split_valid;
    logic [NUM_S*S_AXI_ADDR_WIDTH-1:0] split_addr;
    logic [NUM_S*8-1:0]            split_len;
    logic                          fifo_full, fifo_empty, fifo_pop;
    logic [S-1:0]                  head_start;
    logic [7:0]                    head_len;
    r_state_t                      r_state, r_state_nxt;
    logic [S-1:0]                  r_idx, cur_idx;
    logic [7:0]                    remaining, cur_rem;
    logic                          r_take, m_xfer;
    logic [NUM_S-1:0]              rlast_unused;

    // Manager-side rlast comes from the burst length, not the subordinates.
    assign rlast_unused = m_axi_rlast;

    svc_skidbuf #(.WIDTH(ARW)) u_ar_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axi_arvalid),
        .in_ready (s_axi_arready),
        .in_data  ({s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst}),
        .out_valid(ar_valid),
        .out_ready(ar_ready),
        .out_data (ar_data)
    );

    assign {ar_addr, ar_id, ar_len, ar_size, ar_burst} = ar_data;

    svc_axi_stripe_ax #(
        .NUM_S           (NUM_S),
        .AXI_ADDR_WIDTH  (AW),
        .AXI_DATA_WIDTH  (DW),
        .S_AXI_ADDR_WIDTH(S_AXI_ADDR_WIDTH)
    ) u_ax (
        .addr     (ar_addr),
        .len      (ar_len),
        .start_idx(ar_start),
        .sub_valid(split_valid),
        .sub_addr (split_addr),
        .sub_len  (split_len)
    );

    assign ar_ready  = !fifo_full && ((m_axi_arvalid & ~m_axi_arready) == '0);
    assign ar_accept = ar_valid && ar_ready;

    always_ff @(posedge clk) begin
        if (rst)            m_axi_arvalid <= '0;
        else if (ar_accept) m_axi_arvalid <= split_valid;
        else                m_axi_arvalid <= m_axi_arvalid & ~m_axi_arready;
    end

    always_ff @(posedge clk) begin
        if (ar_accept) begin
            m_axi_araddr  <= split_addr;
            m_axi_arlen   <= split_len;
            m_axi_arid    <= {NUM_S{ar_id}};
            m_axi_arsize  <= {NUM_S{ar_size}};
            m_axi_arburst <= {NUM_S{ar_burst}};
        end
    end

    svc_sync_fifo #(.WIDTH(S + 8), .ADDR_WIDTH(OUTSTANDING_WIDTH)) u_burst_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (ar_accept),
        .wr_data({ar_start, ar_len}),
        .full   (fifo_full),
        .rd_en  (fifo_pop),
        .rd_data({head_start, head_len}),
        .empty  (fifo_empty)
    );

    // In R_HEAD the burst position comes straight from the FIFO head, so a new
    // burst streams without a load bubble.
    always_comb begin
        cur_idx      = (r_state == R_HEAD) ? head_start : r_idx;
        cur_rem      = (r_state == R_HEAD) ? head_len   : remaining;
        r_take       = !fifo_empty && (!s_axi_rvalid || s_axi_rready);
        m_axi_rready = '0;
        if (r_take) m_axi_rready[cur_idx] = 1'b1;
        m_xfer       = r_take && m_axi_rvalid[cur_idx];
        fifo_pop     = m_xfer && (cur_rem == 8'd0);
        r_state_nxt  = r_state;
        if (m_xfer) r_state_nxt = (cur_rem == 8'd0) ? R_HEAD : R_BURST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_HEAD;
            r_idx        <= '0;
            remaining    <= '0;
            s_axi_rvalid <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (m_xfer) begin
                r_idx        <= cur_idx + S'(1);
                remaining    <= cur_rem - 8'd1;
                s_axi_rvalid <= 1'b1;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (m_xfer) begin
            s_axi_rdata <= m_axi_rdata[int'(cur_idx)*DW +: DW];
            s_axi_rid   <= m_axi_rid[int'(cur_idx)*IW +: IW];
            s_axi_rresp <= m_axi_rresp[int'(cur_idx)*2 +: 2];
            s_axi_rlast <= (cur_rem == 8'd0);
        end
    end

endmodule

// File: tb/tb_svc_axi_stripe_rd.sv
// Directed bench for svc_axi_stripe_rd with NUM_S=2, DW=16; subordinates
// return 0xA000 | global byte address so beat order and mapping are visible.
module tb_svc_axi_stripe_rd;

    localparam int NS  = 2;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int SAW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [AW-1:0]     s_axi_araddr  = '0;
    logic [IW-1:0]     s_axi_arid    = '0;
    logic [7:0]        s_axi_arlen   = '0;
    logic [2:0]        s_axi_arsize  = 3'd1;
    logic [1:0]        s_axi_arburst = 2'b01;
    logic              s_axi_rvalid;
    logic              s_axi_rready  = 1'b0;
    logic [IW-1:0]     s_axi_rid;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic [NS-1:0]     m_axi_arvalid;
    logic [NS-1:0]     m_axi_arready = '1;
    logic [NS*SAW-1:0] m_axi_araddr;
    logic [NS*IW-1:0]  m_axi_arid;
    logic [NS*8-1:0]   m_axi_arlen;
    logic [NS*3-1:0]   m_axi_arsize;
    logic [NS*2-1:0]   m_axi_arburst;
    logic [NS-1:0]     m_axi_rvalid;
    logic [NS-1:0]     m_axi_rready;
    logic [NS*IW-1:0]  m_axi_rid;
    logic [NS*DW-1:0]  m_axi_rdata;
    logic [NS*2-1:0]   m_axi_rresp;
    logic [NS-1:0]     m_axi_rlast;

    logic [NS-1:0] sub_en = '0;
    int n_assert = 0;
    int n_fail   = 0;

    svc_axi_stripe_rd #(
        .NUM_S(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .S_AXI_ADDR_WIDTH(SAW), .OUTSTANDING_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
    );

    // Subordinate responders: global address = {sub_addr[6:1], g, sub_addr[0]}.
    for (genvar g = 0; g < NS; g++) begin : g_sub
        typedef struct packed {
            logic [SAW-1:0] addr;
            logic [7:0]     len;
            logic [IW-1:0]  id;
        } ar_t;
        ar_t            q[$];
        logic [7:0]     beat;
        logic           rv = 1'b0;
        logic [DW-1:0]  rd = '0;
        logic [IW-1:0]  ri = '0;
        logic [1:0]     rr = '0;
        logic           rl = 1'b0;
        logic [SAW-1:0] a;
        logic [AW-1:0]  ga;

        assign m_axi_rvalid[g]         = rv;
        assign m_axi_rdata[g*DW +: DW] = rd;
        assign m_axi_rid[g*IW +: IW]   = ri;
        assign m_axi_rresp[g*2 +: 2]   = rr;
        assign m_axi_rlast[g]          = rl;

        always @(posedge clk) begin
            if (rst) begin
                q.delete();
                beat = 8'd0;
                rv  <= 1'b0;
            end else begin
                if (m_axi_arvalid[g] && m_axi_arready[g])
                    q.push_back({m_axi_araddr[g*SAW +: SAW], m_axi_arlen[g*8 +: 8],
                                 m_axi_arid[g*IW +: IW]});
                if (rv && m_axi_rready[g]) begin
                    if (beat == q[0].len) begin
                        void'(q.pop_front());
                        beat = 8'd0;
                    end else begin
                        beat = beat + 8'd1;
                    end
                end
                if (sub_en[g] && q.size() != 0) begin
                    a  = q[0].addr + SAW'(2 * beat);
                    ga = {a[SAW-1:1], 1'(g), a[0]};
                    rv <= 1'b1;
                    rd <= 16'hA000 | 16'(ga);
                    ri <= q[0].id;
                    rr <= (ga == 8'h44) ? 2'b10 : 2'b00;
                    rl <= (beat == q[0].len);
                end else begin
                    rv <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [7:0] addr, input logic [7:0] len, input logic [3:0] id);
        int n = 0;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_handshake", 32'(s_axi_arready), 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic expect_burst(input logic [7:0] addr, input logic [7:0] len,
                                input logic [3:0] id, input bit toggle);
        int         j    = 0;
        int         cyc  = 0;
        bit         held = 0;
        logic [15:0] hd  = '0;
        logic [7:0]  ga;
        while (j <= int'(len) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            s_axi_rready = toggle ? cyc[0] : 1'b1;
            if (s_axi_rvalid) begin
                if (held) check("r_stable", 32'(s_axi_rdata), 32'(hd));
                if (s_axi_rready) begin
                    ga = addr + 8'(2 * j);
                    check("rdata", 32'(s_axi_rdata), 32'(16'hA000 | 16'(ga)));
                    check("rid",   32'(s_axi_rid), 32'(id));
                    check("rlast", 32'(s_axi_rlast), 32'(j == int'(len)));
                    check("rresp", 32'(s_axi_rresp), (ga == 8'h44) ? 2 : 0);
                    j++;
                    held = 0;
                end else begin
                    held = 1;
                    hd   = s_axi_rdata;
                end
            end
        end
        check("r_burst_done", 32'(j > int'(len)), 1);
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        int acc;

        repeat (3) @(negedge clk);
        check("rst_arready", 32'(s_axi_arready), 1);
        check("rst_rvalid",  32'(s_axi_rvalid), 0);
        check("rst_m_arvalid", 32'(m_axi_arvalid), 0);
        check("rst_m_rready",  32'(m_axi_rready), 0);
        rst = 1'b0;
        @(negedge clk);

        // araddr 0x00, len 3: both stripes len 1, addr 0
        send_ar(8'h00, 8'd3, 4'h5);
        @(negedge clk);
        check("t1_arvalid", 32'(m_axi_arvalid), 32'h3);
        check("t1_araddr",  32'(m_axi_araddr), 32'h0000);
        check("t1_arlen",   32'(m_axi_arlen), 32'h0101);
        check("t1_arid",    32'(m_axi_arid), 32'h55);
        check("t1_arsize",  32'(m_axi_arsize), 32'h09);
        check("t1_arburst", 32'(m_axi_arburst), 32'h5);
        sub_en = 2'b11;
        expect_burst(8'h00, 8'd3, 4'h5, 1'b0);

        // araddr 0x02, len 2: m0 addr 0x02 len 0, m1 addr 0x00 len 1
        sub_en = 2'b00;
        send_ar(8'h02, 8'd2, 4'hA);
        @(negedge clk);
        check("t2_arvalid", 32'(m_axi_arvalid), 32'h3);
        check("t2_araddr",  32'(m_axi_araddr), 32'h0002);
        check("t2_arlen",   32'(m_axi_arlen), 32'h0100);
        sub_en = 2'b11;
        expect_burst(8'h02, 8'd2, 4'hA, 1'b0);

        // araddr 0x06, len 0: only m1, addr 0x02
        sub_en = 2'b00;
        send_ar(8'h06, 8'd0, 4'h3);
        @(negedge clk);
        check("t3_arvalid", 32'(m_axi_arvalid), 32'h2);
        check("t3_araddr1", 32'(m_axi_araddr[13:7]), 32'h02);
        check("t3_arlen1",  32'(m_axi_arlen[15:8]), 32'h00);
        @(negedge clk);
        check("t3_arvalid_clr", 32'(m_axi_arvalid), 32'h0);
        sub_en = 2'b11;
        expect_burst(8'h06, 8'd0, 4'h3, 1'b0);

        // back-to-back bursts under 1010 backpressure; 0x44 returns SLVERR
        send_ar(8'h40, 8'd3, 4'h6);
        send_ar(8'h10, 8'd1, 4'h9);
        expect_burst(8'h40, 8'd3, 4'h6, 1'b1);
        expect_burst(8'h10, 8'd1, 4'h9, 1'b1);

        // fill: 8 bursts in the FIFO plus 2 held in the AR skid buffer
        sub_en        = 2'b00;
        s_axi_araddr  = 8'h00;
        s_axi_arlen   = 8'd0;
        s_axi_arid    = 4'h1;
        s_axi_arvalid = 1'b1;
        acc = 0;
        for (int n = 0; n < 20; n++) begin
            if (!s_axi_arready) break;
            acc++;
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        check("full_accepts", 32'(acc), 10);
        repeat (3) @(negedge clk);
        check("full_arready", 32'(s_axi_arready), 0);
        sub_en = 2'b01;
        expect_burst(8'h00, 8'd0, 4'h1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            if (s_axi_arready) break;
            @(negedge clk);
        end
        check("drain_arready", 32'(s_axi_arready), 1);
        for (int b = 0; b < 9; b++) expect_burst(8'h00, 8'd0, 4'h1, 1'b0);

        // reset in the middle of a burst
        sub_en = 2'b11;
        send_ar(8'h00, 8'd3, 4'h2);
        s_axi_rready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid",   32'(s_axi_rvalid), 0);
        check("mid_rst_m_arvalid", 32'(m_axi_arvalid), 0);
        check("mid_rst_m_rready", 32'(m_axi_rready), 0);
        check("mid_rst_arready",  32'(s_axi_arready), 1);
        rst          = 1'b0;
        s_axi_rready = 1'b0;
        @(negedge clk);
        send_ar(8'h02, 8'd2, 4'h4);
        expect_burst(8'h02, 8'd2, 4'h4, 1'b0);

        repeat (3) @(negedge clk);
        check("idle_rvalid", 32'(s_axi_rvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
